// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit hex driver for a common-anode, active-low 7-segment display.
// The count is latched once per frame so that every digit in a frame comes from the same value.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] count,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    logic [PW-1:0] r_p;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic [PW-1:0] w_p_next;
    logic [1:0]    w_idx_next;
    logic [15:0]   w_snap_next;
    logic          w_slot_end;
    logic [3:0]    w_nz;
    logic [3:0]    w_blank;
    logic [3:0]    w_nib;
    logic          w_dark;
    logic [3:0]    w_an_next;
    logic [6:0]    w_seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_slot_end = (r_p == P_LAST);

    always_comb begin
        w_p_next    = w_slot_end ? '0 : r_p + P_ONE;
        w_idx_next  = w_slot_end ? r_idx + 2'd1 : r_idx;
        w_snap_next = (w_slot_end && (r_idx == 2'd3)) ? count : r_snap;
    end

    // Digit k is a leading zero when it and every higher nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign w_nz[gi] = |w_snap_next[4*gi +: 4];
            if (gi == 0) begin : g_units
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_blank[gi] = BLANK_LZ && !(|w_nz[3:gi]);
            end
        end
    endgenerate

    assign w_nib  = w_snap_next[{w_idx_next, 2'b00} +: 4];
    assign w_dark = (w_p_next < P_GUARD) || !enable || w_blank[w_idx_next];

    always_comb begin
        w_an_next  = 4'b1111;
        w_seg_next = 7'b1111111;
        if (!w_dark) begin
            w_an_next  = ~(4'b0001 << w_idx_next);
            w_seg_next = glyph(w_nib);
        end
    end

    // Outputs are registered from next-state values so they line up with (p, idx, snap).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p    <= '0;
            r_idx  <= 2'd0;
            r_snap <= 16'h0000;
            r_an   <= 4'b1111;
            r_seg  <= 7'b1111111;
        end else begin
            r_p    <= w_p_next;
            r_idx  <= w_idx_next;
            r_snap <= w_snap_next;
            r_an   <= w_an_next;
            r_seg  <= w_seg_next;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a cycle-count reference model predicts an/seg/dp,
// a monitor process compares two instances (leading-zero blanking on and off).
module tb_seven_seg_scan_driver;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [15:0] count  = 16'h0000;
    logic        enable = 1'b0;

    logic [3:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    seven_seg_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GUARD), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .reset(reset), .count(count), .enable(enable),
        .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    seven_seg_scan_driver #(.REFRESH_DIV(DIV), .GUARD(GUARD), .BLANK_LZ(1'b0)) dut_all (
        .clk(clk), .reset(reset), .count(count), .enable(enable),
        .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] an_a;
        logic [6:0] seg_a;
        logic [3:0] an_b;
        logic [6:0] seg_b;
    } exp_t;

    exp_t exp_q[$];

    int          tests  = 0;
    int          fails  = 0;
    int          t_m    = 0;
    logic [15:0] snap_m = 16'h0000;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string name, input int t, input logic [11:0] act, input logic [11:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s t=%0d actual an/seg/dp=%03h required=%03h", name, t, act, req);
        end else begin
            $display("[MON] %s t=%0d an/seg/dp=%03h ok", name, t, act);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_lz"},  t_m, {an_a, seg_a, dp_a}, 12'hFFF);
        chk({name, "_all"}, t_m, {an_b, seg_b, dp_b}, 12'hFFF);
    endtask

    // Display as seen t edges after reset release, holding snapshot s.
    function automatic void model_out(input int t, input logic [15:0] s, input logic en,
                                      input bit blz, output logic [3:0] an, output logic [6:0] seg);
        int          p;
        int          idx;
        logic [15:0] upper;
        bit          dark;
        p     = t % DIV;
        idx   = (t / DIV) % 4;
        upper = s >> (4 * idx);
        dark  = (p < GUARD) || !en || (blz && idx != 0 && upper == 16'h0000);
        an    = 4'hF;
        seg   = 7'h7F;
        if (!dark) begin
            an  = ~(4'b0001 << idx);
            seg = glyph[upper[3:0]];
        end
    endfunction

    task automatic predict();
        exp_t e;
        if (t_m % FRAME == FRAME - 1) snap_m = count;
        t_m++;
        e.t = t_m;
        model_out(t_m, snap_m, enable, 1'b1, e.an_a, e.seg_a);
        model_out(t_m, snap_m, enable, 1'b0, e.an_b, e.seg_b);
        exp_q.push_back(e);
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge, move on.
    task automatic step(input logic [15:0] c, input logic en);
        count  = c;
        enable = en;
        predict();
        @(negedge clk);
    endtask

    task automatic do_reset();
        predict();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_reset("async_reset");
        t_m    = 0;
        snap_m = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rnd_count();
        logic [15:0] v;
        int          z;
        v = 16'($urandom);
        z = $urandom_range(0, 4);
        return (z == 4) ? 16'h0000 : (v >> (4 * z));
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scan_lz",  e.t, {an_a, seg_a, dp_a}, {e.an_a, e.seg_a, 1'b1});
            chk("scan_all", e.t, {an_b, seg_b, dp_b}, {e.an_b, e.seg_b, 1'b1});
        end
    end

    initial begin
        logic [15:0] c;
        logic        en;

        #2;
        count  = 16'h1234;
        enable = 1'b1;
        reset  = 1'b1;
        #1;
        chk_reset("reset_init");
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        t_m    = 0;
        snap_m = 16'h0000;

        // Frame 1 shows 0, frame 2 shows 1234.
        repeat (2 * FRAME) step(16'h1234, 1'b1);
        // Leading-zero blanking: 0050 then 0.
        repeat (FRAME) step(16'h0050, 1'b1);
        repeat (FRAME) step(16'h0000, 1'b1);
        repeat (FRAME) step(16'h1111, 1'b1);
        // count changes mid-frame; only the frame-end value is latched.
        for (int k = 0; k < FRAME; k++) step((k < 2 * DIV) ? 16'h1111 : 16'h2222, 1'b1);
        repeat (FRAME) step(16'hFEDC, 1'b1);
        repeat (FRAME) step(16'hBA98, 1'b1);
        repeat (FRAME) step(16'h7654, 1'b1);
        repeat (FRAME) step(16'h3210, 1'b1);
        repeat (FRAME) step(16'h3210, 1'b0);
        for (int k = 0; k < FRAME; k++) step(16'h3210, (k >= 2 * DIV + 5) ? 1'b1 : 1'b0);
        // Reset arriving at p=4 of slot 1.
        while (t_m % FRAME != DIV + 3) step(16'h4321, 1'b1);
        do_reset();
        repeat (FRAME) step(16'hABCD, 1'b1);

        c  = rnd_count();
        en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) c = rnd_count();
            if ($urandom_range(0, 15) == 0) en = ~en;
            if (i == 400) begin
                count  = c;
                enable = en;
                do_reset();
            end else begin
                step(c, en);
            end
        end

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
